// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: turns the IF stage's SRAM-like fetch port into single-beat AXI reads.
// Latency: req->addrok min 1 cycle; R beat->dataok 0 cycles (1 cycle with INST_BRIDGE_RDATA_BUF_EN).
// Backpressure: req is held off while an AR is pending or MAX_OUTSTANDING reads are in flight; R is never stalled.
//
// Ports:
//   clk, reset                      single clock, asynchronous active-high reset
//   inst_sram_req/size/addr         fetch request (wr, wdata ignored)
//   inst_sram_addrok                request accepted (equals the AR handshake)
//   inst_sram_dataok/rdata          returned instruction word, in request order
//   ar*                             AXI read address channel (single ID, single beat)
//   r*                              AXI read data channel (rready tied high)
//
// Build option: define INST_BRIDGE_RDATA_BUF_EN to register the R data path.
`timescale 1ns/1ps

module inst_axi_rd_bridge #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addrok,
  output logic        inst_sram_dataok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  ar_state_t        state;
  ar_state_t        state_nxt;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             ar_hs;
  logic             r_hs;

  // Inputs the read-only, single-ID, in-order bridge has no use for.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wdata, rid, rresp, rlast};

  // Constant AXI fields.
  assign arid    = 4'd0;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  // ---------------- AR FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= AR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    arvalid   = 1'b0;
    case (state)
      AR_IDLE: begin
        if (inst_sram_req && (cnt < MAX_CNT)) begin
          capture   = 1'b1;
          state_nxt = AR_SEND;
        end
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = AR_IDLE;
        end
      end
      default: state_nxt = AR_IDLE;
    endcase
  end

  // Address/size are captured on entry to AR_SEND so they stay stable
  // for the whole AR handshake even if the IF stage changes its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 32'd0;
      size_q <= 2'd0;
    end else if (capture) begin
      addr_q <= inst_sram_addr;
      size_q <= inst_sram_size;
    end
  end

  assign araddr           = addr_q;
  assign arsize           = {1'b0, size_q};
  assign ar_hs            = arvalid && arready;
  assign inst_sram_addrok = ar_hs;
  assign r_hs             = rvalid && rready;

  // ---------------- outstanding counter ----------------
  // A beat arriving with nothing in flight is a slave protocol error;
  // the counter saturates at zero rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- R data path ----------------
`ifdef INST_BRIDGE_RDATA_BUF_EN
  logic        dataok_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataok_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      dataok_q <= r_hs;
      if (r_hs) begin
        rdata_q <= rdata;
      end
    end
  end

  assign inst_sram_dataok = dataok_q;
  assign inst_sram_rdata  = rdata_q;
`else
  assign inst_sram_dataok = r_hs;
  assign inst_sram_rdata  = rdata;
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
`timescale 1ns/1ps

module tb_inst_axi_rd_bridge;

`ifdef INST_BRIDGE_RDATA_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addrok, dataok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] slave_q[$];

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addrok(addrok), .inst_sram_dataok(dataok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // Scoreboard: every AR handshake and every returned word is checked
  // against what the stimulus pushed, in order.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (addrok) begin
        vectors++;
        if (exp_addr.size() == 0) begin
          miscompares++;
          $display("FAIL ar_order: unexpected addrok araddr=%h", araddr);
        end else begin
          e = exp_addr.pop_front();
          if (araddr !== e || arsize !== 3'b010) begin
            miscompares++;
            $display("FAIL ar_order: araddr=%h arsize=%b expected %h / 010", araddr, arsize, e);
          end
        end
      end
      if (dataok) begin
        vectors++;
        if (exp_data.size() == 0) begin
          miscompares++;
          $display("FAIL r_order: unexpected dataok rdata=%h", sram_rdata);
        end else begin
          e = exp_data.pop_front();
          if (sram_rdata !== e) begin
            miscompares++;
            $display("FAIL r_order: rdata=%h expected %h", sram_rdata, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] d);
    req  = 1'b1;
    addr = a;
    size = 2'b10;
    exp_addr.push_back(a);
    exp_data.push_back(d);
    slave_q.push_back(d);
  endtask

  task automatic wait_addrok(input int budget);
    int n = 0;
    @(negedge clk);
    while (addrok !== 1'b1 && n < budget) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (addrok !== 1'b1) begin
      miscompares++;
      $display("FAIL addrok_timeout: addrok=%b after %0d cycles, expected 1", addrok, budget);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic beat();
    rvalid = 1'b1;
    rdata  = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0;
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({arvalid, addrok, dataok, rready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ctrl: arvalid/addrok/dataok/rready=%b expected 0001",
               {arvalid, addrok, dataok, rready});
    end
    vectors++;
    if (araddr !== 32'h0 || arsize !== 3'h0 || sram_rdata !== 32'h0 || dut.cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: araddr=%h arsize=%h rdata=%h cnt=%0d expected zeros",
               araddr, arsize, sram_rdata, dut.cnt);
    end
    vectors++;
    if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'h0, 8'h0, 2'b01, 2'b0, 4'h0, 3'h0}) begin
      miscompares++;
      $display("FAIL reset_const: ar constants=%h expected burst INCR, rest 0",
               {arid, arlen, arburst, arlock, arcache, arprot});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    arready = 1'b1;
    start_req(32'h1fc00000, 32'h24080001);
    step();
    @(negedge clk);
    vectors++;
    if (arvalid !== 1'b1 || araddr !== 32'h1fc00000 || addrok !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ar: arvalid=%b araddr=%h addrok=%b expected 1 1fc00000 1",
               arvalid, araddr, addrok);
    end
    step();
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ar_drop: arvalid=%b expected 0", arvalid);
    end
    step();
    rvalid = 1'b1;
    rdata  = slave_q.pop_front();
    @(negedge clk);
    vectors++;
    if (dataok !== !BUF) begin
      miscompares++;
      $display("FAIL single_dataok_t0: dataok=%b expected %b", dataok, !BUF);
    end
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
    @(negedge clk);
    vectors++;
    if (dataok !== BUF || dut.cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL single_dataok_t1: dataok=%b cnt=%0d expected %b 0", dataok, dut.cnt, BUF);
    end
    step();
  endtask

  task automatic test_ar_stall();
    arready = 1'b0;
    start_req(32'h1fc00010, 32'h11111111);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (arvalid !== 1'b1 || araddr !== 32'h1fc00010 || addrok !== 1'b0) begin
        miscompares++;
        $display("FAIL ar_stall_hold: cycle %0d arvalid=%b araddr=%h addrok=%b expected 1 1fc00010 0",
                 i, arvalid, araddr, addrok);
      end
      step();
    end
    arready = 1'b1;
    @(negedge clk);
    vectors++;
    if (addrok !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_stall_release: addrok=%b expected 1", addrok);
    end
    step();
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (addrok !== 1'b0 || arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_stall_single_pulse: addrok=%b arvalid=%b expected 0 0", addrok, arvalid);
    end
    step();
    beat();
    step();
  endtask

  task automatic test_outstanding();
    arready = 1'b1;
    start_req(32'h1fc00100, 32'ha0000000);
    wait_addrok(8);
    start_req(32'h1fc00104, 32'ha0000001);
    wait_addrok(8);
    vectors++;
    if (dut.cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL outstanding_cnt2: cnt=%0d expected 2", dut.cnt);
    end
    start_req(32'h1fc00108, 32'ha0000002);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (arvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL outstanding_block: cycle %0d arvalid=%b expected 0", i, arvalid);
      end
      step();
    end
    beat();
    @(negedge clk);
    vectors++;
    if (dut.cnt !== 4'd1 || arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL outstanding_cnt1: cnt=%0d arvalid=%b expected 1 0", dut.cnt, arvalid);
    end
    wait_addrok(8);
    beat();
    beat();
    step();
    step();
    vectors++;
    if (dut.cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL outstanding_drain: cnt=%0d expected 0", dut.cnt);
    end
  endtask

  task automatic test_back_to_back();
    arready = 1'b1;
    start_req(32'h1fc00000, 32'hb0000000);
    wait_addrok(8);
    start_req(32'h1fc00004, 32'hb0000004);
    step();
    rvalid = 1'b1;
    rdata  = slave_q.pop_front();
    @(negedge clk);
    vectors++;
    if (addrok !== 1'b1 || rready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_both: addrok=%b rready=%b expected 1 1", addrok, rready);
    end
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
    req    = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut.cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL simul_cnt: cnt=%0d expected 1", dut.cnt);
    end
    start_req(32'h1fc00008, 32'hb0000008);
    wait_addrok(8);
    beat();
    beat();
    step();
    step();
    vectors++;
    if (dut.cnt !== 4'd0 || exp_data.size() != 0) begin
      miscompares++;
      $display("FAIL simul_order_done: cnt=%0d pending words=%0d expected 0 0", dut.cnt, exp_data.size());
    end
  endtask

  task automatic test_async_reset();
    arready = 1'b0;
    start_req(32'h1fc00020, 32'hc0000000);
    step();
    @(negedge clk);
    vectors++;
    if (arvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: arvalid=%b expected 1", arvalid);
    end
    arready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({arvalid, addrok, dataok} !== 3'b000 || dut.cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL areset_immediate: arvalid/addrok/dataok=%b cnt=%0d expected 000 0",
               {arvalid, addrok, dataok}, dut.cnt);
    end
    req     = 1'b0;
    arready = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    slave_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    step();
    arready = 1'b1;
    start_req(32'h1fc00030, 32'hc0000030);
    wait_addrok(8);
    beat();
    step();
    step();
    vectors++;
    if (dut.cnt !== 4'd0 || exp_data.size() != 0) begin
      miscompares++;
      $display("FAIL areset_after: cnt=%0d pending words=%0d expected 0 0", dut.cnt, exp_data.size());
    end
  endtask

  task automatic test_spurious_r();
    exp_data.push_back(32'hdeadbeef);
    rvalid = 1'b1;
    rdata  = 32'hdeadbeef;
    @(negedge clk);
    vectors++;
    if (dataok !== !BUF) begin
      miscompares++;
      $display("FAIL spurious_dataok_t0: dataok=%b expected %b", dataok, !BUF);
    end
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
    @(negedge clk);
    vectors++;
    if (dut.cnt !== 4'd0 || dataok !== BUF) begin
      miscompares++;
      $display("FAIL spurious_cnt: cnt=%0d dataok=%b expected 0 %b", dut.cnt, dataok, BUF);
    end
    step();
    step();
  endtask

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    wr      = 1'b0;
    size    = 2'b10;
    addr    = 32'h0;
    wdata   = 32'h0;
    arready = 1'b0;
    rid     = 4'h0;
    rdata   = 32'h0;
    rresp   = 2'b00;
    rlast   = 1'b1;
    rvalid  = 1'b0;

    test_reset();
    test_single();
    test_ar_stall();
    test_outstanding();
    test_back_to_back();
    test_async_reset();
    test_spurious_r();

    vectors++;
    if (exp_addr.size() != 0 || exp_data.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain: pending addrs=%0d words=%0d expected 0 0",
               exp_addr.size(), exp_data.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
